// File: rtl/mul_seq_pkg.sv
// Shared types and constants for the sequential shift-add multiplier.
// The package is independent of the MUL_SEQ_EARLY_TERM_EN build option.
package mul_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } mul_state_t;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 16;

  // Counter width able to hold the values 0..w
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/mul_seq_cneg.sv
// Combinational conditional two's-complement negate, width-parametrised.
// Used for the operand magnitudes and for the final sign fix-up.
module mul_seq_cneg #(
  parameter int W = 8
) (
  input  logic [W-1:0] i_a,
  input  logic         i_neg,
  output logic [W-1:0] o_y
);

  assign o_y = i_neg ? (~i_a + W'(1)) : i_a;

endmodule

// File: rtl/mul_seq_sxy.sv
// Sequential shift-add multiplier: one multiplier bit per clock, signed or unsigned.
// Build option MUL_SEQ_EARLY_TERM_EN leaves RUN as soon as the remaining multiplier bits are zero.
module mul_seq_sxy
  import mul_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               sign_mode,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  output logic [2*WIDTH-1:0] p,
  output logic               s,
  output logic               rdy,
  output logic               busy
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = cnt_width(WIDTH);

  mul_state_t       r_state;
  mul_state_t       w_state_nxt;

  logic [PW-1:0]    r_mcand;
  logic [PW-1:0]    r_acc;
  logic [PW-1:0]    r_p;
  logic [WIDTH-1:0] r_mult;
  logic [CW-1:0]    r_cnt;
  logic             r_neg;
  logic             r_s;

  logic             w_accept;
  logic             w_x_neg;
  logic             w_y_neg;
  logic [WIDTH-1:0] w_x_mag;
  logic [WIDTH-1:0] w_y_mag;
  logic [WIDTH-1:0] w_mult_nxt;
  logic [PW-1:0]    w_addend;
  logic [PW-1:0]    w_fix_val;
  logic             w_run_last;

  // Operand magnitudes: -2^(WIDTH-1) maps to 2^(WIDTH-1), still exact as unsigned
  assign w_x_neg = sign_mode & x[WIDTH-1];
  assign w_y_neg = sign_mode & y[WIDTH-1];

  mul_seq_cneg #(.W(WIDTH)) u_x_mag (
    .i_a   (x),
    .i_neg (w_x_neg),
    .o_y   (w_x_mag)
  );

  mul_seq_cneg #(.W(WIDTH)) u_y_mag (
    .i_a   (y),
    .i_neg (w_y_neg),
    .o_y   (w_y_mag)
  );

  mul_seq_cneg #(.W(PW)) u_fix (
    .i_a   (r_acc),
    .i_neg (r_neg),
    .o_y   (w_fix_val)
  );

  assign w_accept   = start && ((r_state == IDLE) || (r_state == DONE));
  assign w_mult_nxt = r_mult >> 1;
  assign w_addend   = r_mult[0] ? r_mcand : '0;

`ifdef MUL_SEQ_EARLY_TERM_EN
  assign w_run_last = (w_mult_nxt == '0) || (r_cnt == CW'(WIDTH - 1));
`else
  assign w_run_last = (r_cnt == CW'(WIDTH - 1));
`endif

  // ---- state register ----
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // ---- next-state logic ----
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (start) w_state_nxt = RUN;
      RUN:     if (w_run_last) w_state_nxt = FIX;
      FIX:     w_state_nxt = DONE;
      DONE:    if (start) w_state_nxt = RUN;
      default: w_state_nxt = IDLE;
    endcase
  end

  // ---- state-decoded outputs ----
  always_comb begin
    busy = 1'b0;
    rdy  = 1'b0;
    unique case (r_state)
      RUN, FIX: busy = 1'b1;
      DONE:     rdy  = 1'b1;
      default:  ;
    endcase
  end

  // ---- shift/accumulate datapath ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mcand <= '0;
      r_mult  <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_neg   <= 1'b0;
      r_p     <= '0;
      r_s     <= 1'b0;
    end else if (w_accept) begin
      r_mcand <= PW'(w_x_mag);
      r_mult  <= w_y_mag;
      r_neg   <= w_x_neg ^ w_y_neg;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else if (r_state == RUN) begin
      r_acc   <= r_acc + w_addend;
      r_mcand <= r_mcand << 1;
      r_mult  <= w_mult_nxt;
      r_cnt   <= r_cnt + CW'(1);
    end else if (r_state == FIX) begin
      // Zero never reports negative, even when the operand signs differ
      r_p <= w_fix_val;
      r_s <= r_neg & (r_acc != '0);
    end
  end

  assign p = r_p;
  assign s = r_s;

endmodule

// File: tb/tb_mul_seq_sxy.sv
// Randomised self-checking bench for mul_seq_sxy at WIDTH 8, 3 and 4.
// Expected products come from plain integer multiplication of the interpreted operands.
module tb_mul_seq_sxy;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        st8, sm8, s8, rdy8, busy8;
  logic [7:0]  x8, y8;
  logic [15:0] p8;
  logic        st3, sm3, s3, rdy3, busy3;
  logic [2:0]  x3, y3;
  logic [5:0]  p3;
  logic        st4, sm4, s4, rdy4, busy4;
  logic [3:0]  x4, y4;
  logic [7:0]  p4;

  int checks   = 0;
  int failures = 0;

  mul_seq_sxy #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(st8), .sign_mode(sm8), .x(x8), .y(y8),
    .p(p8), .s(s8), .rdy(rdy8), .busy(busy8)
  );
  mul_seq_sxy #(.WIDTH(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(st3), .sign_mode(sm3), .x(x3), .y(y3),
    .p(p3), .s(s3), .rdy(rdy3), .busy(busy3)
  );
  mul_seq_sxy #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(st4), .sign_mode(sm4), .x(x4), .y(y4),
    .p(p4), .s(s4), .rdy(rdy4), .busy(busy4)
  );

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---- reference model ----
  function automatic int wid(input int inst);
    case (inst)
      0:       return 8;
      1:       return 3;
      default: return 4;
    endcase
  endfunction

  function automatic longint opval(input int w, input bit sm, input int v);
    longint m;
    m = longint'(v) & ((longint'(1) << w) - 1);
    if (sm && (((m >> (w - 1)) & 1) == 1)) m = m - (longint'(1) << w);
    return m;
  endfunction

  function automatic longint ref_p(input int w, input bit sm, input int xv, input int yv);
    return (opval(w, sm, xv) * opval(w, sm, yv)) & ((longint'(1) << (2 * w)) - 1);
  endfunction

  function automatic longint ref_s(input int w, input bit sm, input int xv, input int yv);
    return ((opval(w, sm, xv) * opval(w, sm, yv)) < 0) ? 1 : 0;
  endfunction

  function automatic int ref_lat(input int w, input bit sm, input int yv);
`ifdef MUL_SEQ_EARLY_TERM_EN
    longint m;
    int n;
    m = opval(w, sm, yv);
    if (m < 0) m = -m;
    n = 0;
    while (m != 0) begin
      n++;
      m = m >> 1;
    end
    if (n < 1) n = 1;
    return n + 1;
`else
    if (sm && yv == -12345) return 0;
    return w + 1;
`endif
  endfunction

  // ---- DUT access ----
  task automatic drive(input int inst, input bit st, input bit sm, input int xv, input int yv);
    case (inst)
      0:       begin st8 = st; sm8 = sm; x8 = 8'(xv); y8 = 8'(yv); end
      1:       begin st3 = st; sm3 = sm; x3 = 3'(xv); y3 = 3'(yv); end
      default: begin st4 = st; sm4 = sm; x4 = 4'(xv); y4 = 4'(yv); end
    endcase
  endtask

  function automatic longint get_p(input int inst);
    case (inst)
      0:       return longint'(p8);
      1:       return longint'(p3);
      default: return longint'(p4);
    endcase
  endfunction

  function automatic longint get_s(input int inst);
    case (inst)
      0:       return longint'(s8);
      1:       return longint'(s3);
      default: return longint'(s4);
    endcase
  endfunction

  function automatic logic get_rdy(input int inst);
    case (inst)
      0:       return rdy8;
      1:       return rdy3;
      default: return rdy4;
    endcase
  endfunction

  function automatic logic get_busy(input int inst);
    case (inst)
      0:       return busy8;
      1:       return busy3;
      default: return busy4;
    endcase
  endfunction

  // One operation with start pulsed for a single cycle; operands scrambled after acceptance
  task automatic do_op(input int inst, input bit sm, input int xv, input int yv, input string tag);
    int     w;
    int     cyc;
    longint p_before;
    bit     stable;
    w      = wid(inst);
    cyc    = 0;
    stable = 1'b1;
    @(negedge clk);
    drive(inst, 1'b1, sm, xv, yv);
    @(posedge clk);
    #1;
    p_before = get_p(inst);
    drive(inst, 1'b0, 1'($urandom), int'($urandom), int'($urandom));
    check_eq({tag, ".busy_on_accept"}, longint'(get_busy(inst)), 1);
    check_eq({tag, ".rdy_on_accept"}, longint'(get_rdy(inst)), 0);
    while (!get_rdy(inst) && cyc < 64) begin
      @(posedge clk);
      #1;
      cyc++;
      if (!get_rdy(inst) && get_p(inst) != p_before) stable = 1'b0;
    end
    check_eq({tag, ".latency"}, longint'(cyc), longint'(ref_lat(w, sm, yv)));
    check_eq({tag, ".p"}, get_p(inst), ref_p(w, sm, xv, yv));
    check_eq({tag, ".s"}, get_s(inst), ref_s(w, sm, xv, yv));
    check_eq({tag, ".p_held_while_busy"}, longint'(stable), 1);
    check_eq({tag, ".busy_done"}, longint'(get_busy(inst)), 0);
  endtask

  // Start held high: noise during RUN is ignored, DONE re-accepts immediately
  task automatic b2b(input int n);
    int xv, yv, nx, ny, cyc;
    bit sm, nsm;
    xv = int'($urandom_range(0, 255));
    yv = int'($urandom_range(0, 255));
    sm = 1'($urandom);
    @(negedge clk);
    drive(0, 1'b1, sm, xv, yv);
    @(posedge clk);
    #1;
    for (int i = 0; i < n; i++) begin
      cyc = 0;
      while (!rdy8 && cyc < 64) begin
        drive(0, 1'b1, 1'($urandom), int'($urandom), int'($urandom));
        @(posedge clk);
        #1;
        cyc++;
      end
      check_eq("b2b.latency", longint'(cyc), longint'(ref_lat(8, sm, yv)));
      check_eq("b2b.p", longint'(p8), ref_p(8, sm, xv, yv));
      check_eq("b2b.s", longint'(s8), ref_s(8, sm, xv, yv));
      if (i < n - 1) begin
        nx  = int'($urandom_range(0, 255));
        ny  = int'($urandom_range(0, 255));
        nsm = 1'($urandom);
        drive(0, 1'b1, nsm, nx, ny);
        @(posedge clk);
        #1;
        check_eq("b2b.rdy_drop", longint'(rdy8), 0);
        check_eq("b2b.busy_rise", longint'(busy8), 1);
        xv = nx;
        yv = ny;
        sm = nsm;
      end
    end
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 0, 0);
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 0, 0);
    drive(1, 1'b0, 1'b0, 0, 0);
    drive(2, 1'b0, 1'b0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset.p", longint'(p8), 0);
    check_eq("reset.s", longint'(s8), 0);
    check_eq("reset.rdy", longint'(rdy8), 0);
    check_eq("reset.busy", longint'(busy8), 0);
    @(negedge clk);
    rst = 1'b0;

    do_op(0, 1'b1, -3, 5, "signed_m3x5");
    check_eq("signed_m3x5.p_const", longint'(p8), 64'hFFF1);

    // Abandon an unsigned 7*3 mid-RUN
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 7, 3);
    @(posedge clk);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_eq("midrun_rst.p", longint'(p8), 0);
    check_eq("midrun_rst.s", longint'(s8), 0);
    check_eq("midrun_rst.rdy", longint'(rdy8), 0);
    check_eq("midrun_rst.busy", longint'(busy8), 0);
    @(negedge clk);
    rst = 1'b0;
    do_op(0, 1'b0, 7, 3, "after_rst_7x3");

    do_op(0, 1'b1, -128, -128, "ext_m128sq");
    check_eq("ext_m128sq.p_const", longint'(p8), 64'h4000);
    do_op(0, 1'b1, -128, 127, "ext_m128x127");
    check_eq("ext_m128x127.p_const", longint'(p8), 64'hC080);
    do_op(0, 1'b0, 255, 255, "ext_u255sq");
    check_eq("ext_u255sq.p_const", longint'(p8), 64'hFE01);
    do_op(0, 1'b1, -5, 0, "zero_m5x0");

    b2b(5);

    for (int i = 0; i < 40; i++)
      do_op(0, 1'($urandom), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), "rand8");

    for (int inst = 1; inst < 3; inst++)
      for (int sm = 0; sm < 2; sm++)
        for (int a = 0; a < (1 << wid(inst)); a++)
          for (int b = 0; b < (1 << wid(inst)); b++)
            do_op(inst, 1'(sm), a, b, (inst == 1) ? "sweep3" : "sweep4");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
